// File: rtl/riscv_opcodes_pkg.sv
// RV32/RV64 major opcodes and load funct3 encodings used by write-back.
package riscv_opcodes_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Non-load instructions that produce an rd value; CSR ops are SYSTEM with funct3 != 0.
    function automatic logic writes_rd(input logic [6:0] opcode, input logic [2:0] funct3);
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_OP_IMM, OPC_OP, OPC_OP_IMM32, OPC_OP32: writes_rd = 1'b1;
            OPC_SYSTEM:                                 writes_rd = (funct3 != 3'b000);
            default:                                    writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_state_pkg.sv
// FSM state encodings for pipeline stages.
package riscv_state_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/riscv_wb_load_pkg.sv
// Pipeline payload types shared between the memory and write-back stages.
package riscv_wb_load_pkg;

    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic            bubble;
        logic            retired;
        logic            dbg;
        logic [ILEN-1:0] instr;
    } instruction_t;

    typedef struct packed {
        logic any;
        logic illegal_instruction;
        logic load_misaligned;
        logic load_access_fault;
    } interrupts_exceptions_t;

    localparam instruction_t INSN_BUBBLE = '{bubble: 1'b1, retired: 1'b0, dbg: 1'b0, instr: '0};

endpackage

// File: rtl/riscv_wb_load_align.sv
// Load data alignment: shifts the addressed lane down and sign/zero-extends by funct3.
module riscv_wb_load_align
    import riscv_opcodes_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  dmem_q,
    output logic [XLEN-1:0]  data_c
);

    logic [XLEN-1:0] shifted_c;

    assign shifted_c = dmem_q >> {off, 3'b000};

    always_comb begin
        data_c = shifted_c;
        case (funct3)
            F3_LB:   data_c = XLEN'($signed(shifted_c[7:0]));
            F3_LH:   data_c = XLEN'($signed(shifted_c[15:0]));
            F3_LW:   data_c = XLEN'($signed(shifted_c[31:0]));
            F3_LBU:  data_c = XLEN'(shifted_c[7:0]);
            F3_LHU:  data_c = XLEN'(shifted_c[15:0]);
            F3_LWU:  data_c = XLEN'(shifted_c[31:0]);
            default: data_c = shifted_c;
        endcase
    end

endmodule

// File: rtl/riscv_wb_load.sv
// Write-back stage: completes loads against the data-memory response and drives the RF write port.
// Optional dmem response timeout is compiled in with RISCV_WB_DMEM_TIMEOUT_EN.
module riscv_wb_load
    import riscv_wb_load_pkg::*;
    import riscv_state_pkg::*;
    import riscv_opcodes_pkg::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter logic [XLEN-1:0] PC_INIT = XLEN'('h200),
    parameter int unsigned     TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    output logic                   wb_stall_o,
    input  logic [XLEN-1:0]        wb_pc_i,
    input  instruction_t           wb_insn_i,
    input  interrupts_exceptions_t wb_exceptions_i,
    input  logic [XLEN-1:0]        wb_r_i,
    input  logic [XLEN-1:0]        wb_memadr_i,
    input  logic                   dmem_ack_i,
    input  logic                   dmem_err_i,
    input  logic [XLEN-1:0]        dmem_q_i,
    output logic [XLEN-1:0]        wb_pc_o,
    output instruction_t           wb_insn_o,
    output interrupts_exceptions_t wb_exceptions_o,
    output logic                   wb_we_o,
    output logic [4:0]             wb_dst_o,
    output logic [XLEN-1:0]        wb_r_o
);

    localparam int unsigned OFF_W = $clog2(XLEN / 8);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("riscv_wb_load: XLEN must be 32 or 64");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("riscv_wb_load: TIMEOUT must be in 1..65535");
    end

    wb_state_t              state_q, state_d;
    logic [6:0]             opcode_c;
    logic [4:0]             rd_c;
    logic [2:0]             funct3_c;
    logic                   valid_c, load_c, fault_c, timeout_c;
    logic [XLEN-1:0]        align_c;
    instruction_t           insn_d;
    interrupts_exceptions_t exc_d;
    logic                   we_d;
    logic [4:0]             dst_d;
    logic [XLEN-1:0]        r_d;
    logic                   unused_adr;

    assign opcode_c   = wb_insn_i.instr[6:0];
    assign rd_c       = wb_insn_i.instr[11:7];
    assign funct3_c   = wb_insn_i.instr[14:12];
    assign valid_c    = !wb_insn_i.bubble && !wb_exceptions_i.any;
    assign load_c     = valid_c && (opcode_c == OPC_LOAD);
    assign fault_c    = dmem_err_i || timeout_c;
    assign unused_adr = ^wb_memadr_i[XLEN-1:OFF_W];

`ifdef RISCV_WB_DMEM_TIMEOUT_EN
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = (TW < 8) ? 8 : ((TW > 16) ? 16 : TW);

    logic [CNT_W-1:0] cnt_q;

    // Counts WAIT cycles; the IDLE cycle that issued the wait is the first stall cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q != WAIT) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
`endif

    riscv_wb_load_align #(
        .XLEN (XLEN),
        .OFF_W(OFF_W)
    ) u_align (
        .funct3(funct3_c),
        .off   (wb_memadr_i[OFF_W-1:0]),
        .dmem_q(dmem_q_i),
        .data_c(align_c)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wb_stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_c && !dmem_ack_i && !fault_c) begin
                    state_d    = WAIT;
                    wb_stall_o = 1'b1;
                end
            end
            WAIT: begin
                if (load_c && !dmem_ack_i && !fault_c) begin
                    wb_stall_o = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion decode: only a retiring instruction clears bubble; a fault outranks ack.
    always_comb begin
        insn_d         = wb_insn_i;
        insn_d.bubble  = 1'b1;
        insn_d.retired = 1'b0;
        exc_d          = wb_insn_i.bubble ? '0 : wb_exceptions_i;
        we_d           = 1'b0;
        dst_d          = wb_insn_i.bubble ? 5'd0 : rd_c;
        r_d            = wb_r_i;
        if (load_c) begin
            if (fault_c) begin
                exc_d.any               = 1'b1;
                exc_d.load_access_fault = 1'b1;
            end else if (dmem_ack_i) begin
                insn_d.bubble  = 1'b0;
                insn_d.retired = 1'b1;
                we_d           = (rd_c != 5'd0);
                r_d            = align_c;
            end
        end else if (valid_c) begin
            insn_d.bubble  = 1'b0;
            insn_d.retired = 1'b1;
            we_d           = writes_rd(opcode_c, funct3_c) && (rd_c != 5'd0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_pc_o         <= PC_INIT;
            wb_insn_o       <= INSN_BUBBLE;
            wb_exceptions_o <= '0;
            wb_we_o         <= 1'b0;
            wb_dst_o        <= 5'd0;
            wb_r_o          <= '0;
        end else begin
            wb_pc_o         <= wb_pc_i;
            wb_insn_o       <= insn_d;
            wb_exceptions_o <= exc_d;
            wb_we_o         <= we_d;
            wb_dst_o        <= dst_d;
            wb_r_o          <= r_d;
        end
    end

endmodule

// File: tb/tb_riscv_wb_load.sv
// Directed bench for riscv_wb_load (XLEN=32, TIMEOUT=4); honours RISCV_WB_DMEM_TIMEOUT_EN.
module tb_riscv_wb_load;
    import riscv_wb_load_pkg::*;

    localparam int unsigned XLEN = 32;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   wb_stall_o;
    logic [XLEN-1:0]        wb_pc_i;
    instruction_t           wb_insn_i;
    interrupts_exceptions_t wb_exceptions_i;
    logic [XLEN-1:0]        wb_r_i;
    logic [XLEN-1:0]        wb_memadr_i;
    logic                   dmem_ack_i;
    logic                   dmem_err_i;
    logic [XLEN-1:0]        dmem_q_i;
    logic [XLEN-1:0]        wb_pc_o;
    instruction_t           wb_insn_o;
    interrupts_exceptions_t wb_exceptions_o;
    logic                   wb_we_o;
    logic [4:0]             wb_dst_o;
    logic [XLEN-1:0]        wb_r_o;

    int total = 0;
    int bad   = 0;
    int n_stall;
    interrupts_exceptions_t exc_exp;

    riscv_wb_load #(
        .XLEN   (XLEN),
        .PC_INIT(32'h200),
        .TIMEOUT(4)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wb_stall_o     (wb_stall_o),
        .wb_pc_i        (wb_pc_i),
        .wb_insn_i      (wb_insn_i),
        .wb_exceptions_i(wb_exceptions_i),
        .wb_r_i         (wb_r_i),
        .wb_memadr_i    (wb_memadr_i),
        .dmem_ack_i     (dmem_ack_i),
        .dmem_err_i     (dmem_err_i),
        .dmem_q_i       (dmem_q_i),
        .wb_pc_o        (wb_pc_o),
        .wb_insn_o      (wb_insn_o),
        .wb_exceptions_o(wb_exceptions_o),
        .wb_we_o        (wb_we_o),
        .wb_dst_o       (wb_dst_o),
        .wb_r_o         (wb_r_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] r,
                         input logic [31:0] adr, input logic [31:0] q, input logic ack,
                         input logic err);
        wb_pc_i         = pc;
        wb_insn_i       = '{bubble: 1'b0, retired: 1'b0, dbg: 1'b0, instr: instr};
        wb_exceptions_i = '0;
        wb_r_i          = r;
        wb_memadr_i     = adr;
        dmem_q_i        = q;
        dmem_ack_i      = ack;
        dmem_err_i      = err;
    endtask

    task automatic idle_in();
        wb_insn_i       = INSN_BUBBLE;
        wb_exceptions_i = '0;
        dmem_ack_i      = 1'b0;
        dmem_err_i      = 1'b0;
    endtask

    initial begin
        wb_pc_i     = '0;
        wb_r_i      = '0;
        wb_memadr_i = '0;
        dmem_q_i    = '0;
        idle_in();
        repeat (2) cyc();

        chk("rst_pc", wb_pc_o, 32'h200);
        chk("rst_bubble", 32'(wb_insn_o.bubble), 32'd1);
        chk("rst_retired", 32'(wb_insn_o.retired), 32'd0);
        chk("rst_dbg", 32'(wb_insn_o.dbg), 32'd0);
        chk("rst_exc", 32'(wb_exceptions_o), 32'd0);
        chk("rst_we", 32'(wb_we_o), 32'd0);
        chk("rst_dst", 32'(wb_dst_o), 32'd0);
        chk("rst_r", wb_r_o, 32'd0);
        rst_i = 1'b0;
        cyc();

        // ADDI x5
        issue(32'h100, 32'h0000_0293, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0);
        #1 chk("addi_stall", 32'(wb_stall_o), 32'd0);
        cyc();
        chk("addi_we", 32'(wb_we_o), 32'd1);
        chk("addi_dst", 32'(wb_dst_o), 32'd5);
        chk("addi_r", wb_r_o, 32'h1234);
        chk("addi_retired", 32'(wb_insn_o.retired), 32'd1);
        chk("addi_pc", wb_pc_o, 32'h100);

        // LB x6 from byte 3, ack in the same cycle
        issue(32'h104, 32'h0000_0303, 32'h0, 32'h103, 32'h8012_3456, 1'b1, 1'b0);
        #1 chk("lb_stall", 32'(wb_stall_o), 32'd0);
        cyc();
        chk("lb_r", wb_r_o, 32'hFFFF_FF80);
        chk("lb_we", 32'(wb_we_o), 32'd1);
        chk("lb_dst", 32'(wb_dst_o), 32'd6);

        // LHU x7 from half 1, ack after three stall cycles
        issue(32'h108, 32'h0000_5383, 32'h0, 32'h102, 32'hBEEF_1234, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("lhu_stall", 32'(wb_stall_o), 32'd1);
            cyc();
            chk("lhu_wait_we", 32'(wb_we_o), 32'd0);
            chk("lhu_wait_bubble", 32'(wb_insn_o.bubble), 32'd1);
        end
        dmem_ack_i = 1'b1;
        #1 chk("lhu_ack_stall", 32'(wb_stall_o), 32'd0);
        cyc();
        chk("lhu_r", wb_r_o, 32'h0000_BEEF);
        chk("lhu_we", 32'(wb_we_o), 32'd1);
        chk("lhu_retired", 32'(wb_insn_o.retired), 32'd1);
        idle_in();
        cyc();
        chk("lhu_we_once", 32'(wb_we_o), 32'd0);

        // LW x8 with err and ack together
        issue(32'h10C, 32'h0000_2403, 32'h0, 32'h100, 32'h1122_3344, 1'b1, 1'b1);
        #1 chk("lwerr_stall", 32'(wb_stall_o), 32'd0);
        cyc();
        exc_exp = '{any: 1'b1, illegal_instruction: 1'b0, load_misaligned: 1'b0, load_access_fault: 1'b1};
        chk("lwerr_we", 32'(wb_we_o), 32'd0);
        chk("lwerr_exc", 32'(wb_exceptions_o), 32'(exc_exp));
        chk("lwerr_bubble", 32'(wb_insn_o.bubble), 32'd1);
        chk("lwerr_retired", 32'(wb_insn_o.retired), 32'd0);

        // LW x0: retires without writing
        issue(32'h110, 32'h0000_2003, 32'h0, 32'h100, 32'hCAFE_F00D, 1'b1, 1'b0);
        cyc();
        chk("lwx0_we", 32'(wb_we_o), 32'd0);
        chk("lwx0_retired", 32'(wb_insn_o.retired), 32'd1);

        // LBU x9 byte 1 and LH x10 half 1
        issue(32'h114, 32'h0000_4483, 32'h0, 32'h101, 32'h0000_A500, 1'b1, 1'b0);
        cyc();
        chk("lbu_r", wb_r_o, 32'h0000_00A5);
        issue(32'h118, 32'h0000_1503, 32'h0, 32'h102, 32'h8001_FFFF, 1'b1, 1'b0);
        cyc();
        chk("lh_r", wb_r_o, 32'hFFFF_8001);
        chk("lh_dst", 32'(wb_dst_o), 32'd10);

        // Store with rd field 10: retires, no write
        issue(32'h11C, 32'h0000_0523, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        cyc();
        chk("sw_we", 32'(wb_we_o), 32'd0);
        chk("sw_retired", 32'(wb_insn_o.retired), 32'd1);

        // Incoming exception is forwarded as a bubble
        issue(32'h120, 32'h0000_0293, 32'h77, 32'h0, 32'h0, 1'b0, 1'b0);
        exc_exp = '{any: 1'b1, illegal_instruction: 1'b1, load_misaligned: 1'b0, load_access_fault: 1'b0};
        wb_exceptions_i = exc_exp;
        cyc();
        chk("exc_fwd", 32'(wb_exceptions_o), 32'(exc_exp));
        chk("exc_we", 32'(wb_we_o), 32'd0);
        chk("exc_bubble", 32'(wb_insn_o.bubble), 32'd1);

        // Reset while waiting, then a stray ack
        issue(32'h300, 32'h0000_2403, 32'h55, 32'h100, 32'h1122_3344, 1'b0, 1'b0);
        cyc();
        chk("wait_stall", 32'(wb_stall_o), 32'd1);
        chk("wait_pc", wb_pc_o, 32'h300);
        rst_i = 1'b1;
        #1;
        chk("midrst_pc", wb_pc_o, 32'h200);
        chk("midrst_r", wb_r_o, 32'd0);
        chk("midrst_we", 32'(wb_we_o), 32'd0);
        chk("midrst_bubble", 32'(wb_insn_o.bubble), 32'd1);
        chk("midrst_dst", 32'(wb_dst_o), 32'd0);
        idle_in();
        cyc();
        rst_i = 1'b0;
        cyc();
        dmem_ack_i = 1'b1;
        #1 chk("stray_stall", 32'(wb_stall_o), 32'd0);
        cyc();
        chk("stray_we", 32'(wb_we_o), 32'd0);
        chk("stray_bubble", 32'(wb_insn_o.bubble), 32'd1);
        dmem_ack_i = 1'b0;
        cyc();

        // Load that never gets a response
        issue(32'h400, 32'h0000_2403, 32'h0, 32'h100, 32'h0BAD_F00D, 1'b0, 1'b0);
        #1;
        n_stall = 0;
`ifdef RISCV_WB_DMEM_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            if (!wb_stall_o) break;
            n_stall++;
            cyc();
        end
        chk("to_stall_cycles", 32'(n_stall), 32'd4);
        cyc();
        exc_exp = '{any: 1'b1, illegal_instruction: 1'b0, load_misaligned: 1'b0, load_access_fault: 1'b1};
        chk("to_exc", 32'(wb_exceptions_o), 32'(exc_exp));
        chk("to_we", 32'(wb_we_o), 32'd0);
        chk("to_bubble", 32'(wb_insn_o.bubble), 32'd1);
`else
        for (int i = 0; i < 100; i++) begin
            if (!wb_stall_o) break;
            n_stall++;
            cyc();
        end
        chk("nto_stall_cycles", 32'(n_stall), 32'd100);
        chk("nto_still_stall", 32'(wb_stall_o), 32'd1);
        chk("nto_exc", 32'(wb_exceptions_o), 32'd0);
        dmem_ack_i = 1'b1;
        cyc();
        chk("nto_r", wb_r_o, 32'h0BAD_F00D);
        chk("nto_we", 32'(wb_we_o), 32'd1);
`endif
        idle_in();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
